// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared types and constants for the load/store unit
// Purpose : access-size encodings (shared with the store-data mask stage),
//           LSU FSM state enum, byte-enable lane constants and
//           sign-extension width constants.
// Ports   : none (package).
package riscv_lsu_pkg;

    // Access size select; 2'b11 is not a legal encoding and is handled as a word.
    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_X = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Byte-enable patterns before shifting onto the addressed lane.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Widths of the narrow load results that get extended.
    localparam int SEXT_B_W = 8;
    localparam int SEXT_H_W = 16;

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - combinational byte-lane steering for the LSU
// Purpose : turns access size + address offset into byte enables, places
//           store data on its lane(s), and extracts/extends load data.
// Ports   : size_i     access size (MASK_B/MASK_H/MASK_X, others = word)
//           offset_i   address bits [1:0]
//           unsigned_i load zero-extend (1) / sign-extend (0)
//           wdata_i    store data, value in the low bits
//           rdata_i    raw word read from memory
//           be_o       byte enables for a store
//           wdata_o    lane-aligned store data
//           rdata_o    extended load result
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [1:0]             size_i,
    input  logic [1:0]             offset_i,
    input  logic                   unsigned_i,
    input  logic [WORD_LENGTH-1:0] wdata_i,
    input  logic [WORD_LENGTH-1:0] rdata_i,
    output logic [3:0]             be_o,
    output logic [WORD_LENGTH-1:0] wdata_o,
    output logic [WORD_LENGTH-1:0] rdata_o
);

    logic [1:0]             lane;
    logic [WORD_LENGTH-1:0] shifted;
    logic                   fill_b;
    logic                   fill_h;

    // Offset bits below the access size are dropped, so a half uses addr[1]
    // only and a word always sits on lane 0.
    always_comb begin
        lane = 2'd0;
        be_o = BE_WORD;
        case (size_i)
            MASK_B: begin
                lane = offset_i;
                be_o = BE_BYTE << offset_i;
            end
            MASK_H: begin
                lane = {offset_i[1], 1'b0};
                be_o = BE_HALF << {offset_i[1], 1'b0};
            end
            default: begin
                lane = 2'd0;
                be_o = BE_WORD;
            end
        endcase
    end

    assign wdata_o = wdata_i << {lane, 3'b000};
    assign shifted = rdata_i >> {lane, 3'b000};
    assign fill_b  = ~unsigned_i & shifted[SEXT_B_W-1];
    assign fill_h  = ~unsigned_i & shifted[SEXT_H_W-1];

    always_comb begin
        rdata_o = shifted;
        case (size_i)
            MASK_B:  rdata_o = {{(WORD_LENGTH-SEXT_B_W){fill_b}}, shifted[SEXT_B_W-1:0]};
            MASK_H:  rdata_o = {{(WORD_LENGTH-SEXT_H_W){fill_h}}, shifted[SEXT_H_W-1:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - memory-stage load/store unit with req/ack data bus
// Purpose : accepts one access at a time, runs it on the data-memory bus
//           and stalls the pipeline until the access completes.
// Config  : RISCV_MISALIGN_TRAP_EN - when defined, misaligned halves/words
//           finish immediately with lsu_misalign=1 and no bus cycle.
// Ports   : clk, rst (sync, active high)
//           lsu_valid/lsu_we/lsu_size/lsu_unsigned/lsu_addr/lsu_wdata  access in
//           lsu_stall, lsu_done, lsu_rdata, lsu_misalign               access out
//           dmem_req/dmem_we/dmem_addr/dmem_be/dmem_wdata              bus out
//           dmem_ack/dmem_rdata                                        bus in
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lsu_valid,
    input  logic                   lsu_we,
    input  logic [1:0]             lsu_size,
    input  logic                   lsu_unsigned,
    input  logic [WORD_LENGTH-1:0] lsu_addr,
    input  logic [WORD_LENGTH-1:0] lsu_wdata,
    output logic                   lsu_stall,
    output logic                   lsu_done,
    output logic [WORD_LENGTH-1:0] lsu_rdata,
    output logic                   lsu_misalign,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [WORD_LENGTH-1:0] dmem_addr,
    output logic [3:0]             dmem_be,
    output logic [WORD_LENGTH-1:0] dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [WORD_LENGTH-1:0] dmem_rdata
);

    lsu_state_e             state_q;
    logic [1:0]             size_q;
    logic [1:0]             offset_q;
    logic                   unsigned_q;
    logic                   done_q;
    logic                   misalign_q;
    logic [WORD_LENGTH-1:0] rdata_q;
    logic                   req_q;
    logic                   we_q;
    logic [WORD_LENGTH-1:0] addr_q;
    logic [3:0]             be_q;
    logic [WORD_LENGTH-1:0] wdata_q;

    logic [1:0]             al_size;
    logic [1:0]             al_offset;
    logic [3:0]             al_be;
    logic [WORD_LENGTH-1:0] al_wdata;
    logic [WORD_LENGTH-1:0] al_rdata;
    logic                   trap;

    // One steering instance: in IDLE it sees the incoming access (store lane
    // placement is registered at accept), in BUS it sees the latched request
    // (load extraction at ack).
    assign al_size   = (state_q == LSU_IDLE) ? lsu_size      : size_q;
    assign al_offset = (state_q == LSU_IDLE) ? lsu_addr[1:0] : offset_q;

    riscv_lsu_align #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_align (
        .size_i    (al_size),
        .offset_i  (al_offset),
        .unsigned_i(unsigned_q),
        .wdata_i   (lsu_wdata),
        .rdata_i   (dmem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

`ifdef RISCV_MISALIGN_TRAP_EN
    assign trap = ((lsu_size == MASK_H) && lsu_addr[0]) ||
                  ((lsu_size != MASK_B) && (lsu_size != MASK_H) && (lsu_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            size_q     <= MASK_B;
            offset_q   <= 2'b00;
            unsigned_q <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    rdata_q    <= '0;
                    if (lsu_valid) begin
                        if (trap) begin
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                            state_q    <= LSU_DONE;
                        end else begin
                            size_q     <= lsu_size;
                            offset_q   <= lsu_addr[1:0];
                            unsigned_q <= lsu_unsigned;
                            req_q      <= 1'b1;
                            we_q       <= lsu_we;
                            addr_q     <= {lsu_addr[WORD_LENGTH-1:2], 2'b00};
                            be_q       <= lsu_we ? al_be : BE_WORD;
                            wdata_q    <= lsu_we ? al_wdata : '0;
                            state_q    <= LSU_BUS;
                        end
                    end
                end
                LSU_BUS: begin
                    // Bus outputs are untouched until the ack, so they stay stable.
                    if (dmem_ack) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        rdata_q <= we_q ? '0 : al_rdata;
                        done_q  <= 1'b1;
                        state_q <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    rdata_q    <= '0;
                    state_q    <= LSU_IDLE;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign lsu_stall    = lsu_valid & ~done_q;
    assign lsu_done     = done_q;
    assign lsu_rdata    = rdata_q;
    assign lsu_misalign = misalign_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed scoreboard bench for riscv_lsu
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic        mis;
        int          stalls;
        int          bus;
    } exp_t;

    exp_t sb[$];

    riscv_lsu #(.WORD_LENGTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .lsu_valid   (lsu_valid),
        .lsu_we      (lsu_we),
        .lsu_size    (lsu_size),
        .lsu_unsigned(lsu_unsigned),
        .lsu_addr    (lsu_addr),
        .lsu_wdata   (lsu_wdata),
        .lsu_stall   (lsu_stall),
        .lsu_done    (lsu_done),
        .lsu_rdata   (lsu_rdata),
        .lsu_misalign(lsu_misalign),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic we,
                                input logic [31:0] rdata, input logic mis,
                                input int stalls, input int bus);
        exp_t e;
        e.addr = addr; e.be = be; e.wdata = wdata; e.we = we;
        e.rdata = rdata; e.mis = mis; e.stalls = stalls; e.bus = bus;
        return e;
    endfunction

    // Presents one access, acks it after `delay` request cycles, and checks
    // bus fields every BUS cycle plus the response at lsu_done.
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int delay, input exp_t e,
                          input logic hold);
        exp_t got;
        int   stalls;
        int   reqs;
        bit   done_seen;
        stalls = 0; reqs = 0; done_seen = 0;
        @(negedge clk);
        sb.push_back(e);
        lsu_valid = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wdata;
        #1;
        for (int cyc = 0; cyc < 50 && !done_seen; cyc++) begin
            if (lsu_done) begin
                done_seen = 1;
                dmem_ack  = 1'b0;
                got = sb.pop_front();
                chk({tag, "_rdata"}, lsu_rdata, got.rdata);
                chk({tag, "_misalign"}, {31'd0, lsu_misalign}, {31'd0, got.mis});
                chk({tag, "_stall_at_done"}, {31'd0, lsu_stall}, 32'd0);
            end else begin
                if (lsu_stall) stalls++;
                if (dmem_req) begin
                    chk({tag, "_addr"}, dmem_addr, e.addr);
                    chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, e.be});
                    chk({tag, "_wdata"}, dmem_wdata, e.wdata);
                    chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, e.we});
                    dmem_ack   = (reqs == delay);
                    dmem_rdata = dmem_ack ? rd : 32'hDEAD_BEEF;
                    reqs++;
                end else begin
                    dmem_ack = 1'b0;
                end
                @(negedge clk);
                #1;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
        chk({tag, "_stall_cycles"}, stalls, e.stalls);
        chk({tag, "_bus_cycles"}, reqs, e.bus);
        if (!hold) begin
            @(negedge clk);
            lsu_valid = 1'b0;
            #1;
            chk({tag, "_idle_req"}, {31'd0, dmem_req}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_size = MASK_B;
        lsu_unsigned = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_done", {31'd0, lsu_done}, 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_misalign", {31'd0, lsu_misalign}, 32'd0);
        rst = 1'b0;

        // 1: SB to lane 3, ack in first BUS cycle
        access("sb", 1'b1, MASK_B, 1'b0, 32'h103, 32'h0000_00AB, 32'h0, 0,
               mk(32'h100, 4'b1000, 32'hAB00_0000, 1'b1, 32'h0, 1'b0, 2, 1), 1'b0);

        // 2: LH upper half, sign-extended, ack delayed 3 cycles
        access("lh", 1'b0, MASK_H, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 3,
               mk(32'h200, 4'b1111, 32'h0, 1'b0, 32'hFFFF_8001, 1'b0, 5, 4), 1'b0);

        // 3: LBU / LB on lane 1
        access("lbu", 1'b0, MASK_B, 1'b1, 32'h001, 32'h0, 32'h0000_F000, 0,
               mk(32'h000, 4'b1111, 32'h0, 1'b0, 32'h0000_00F0, 1'b0, 2, 1), 1'b0);
        access("lb", 1'b0, MASK_B, 1'b0, 32'h001, 32'h0, 32'h0000_F000, 1,
               mk(32'h000, 4'b1111, 32'h0, 1'b0, 32'hFFFF_FFF0, 1'b0, 3, 2), 1'b0);

        // Extra lane cases: LHU lower half, SH upper half, invalid size as word
        access("lhu", 1'b0, MASK_H, 1'b1, 32'h204, 32'h0, 32'h1234_9ABC, 0,
               mk(32'h204, 4'b1111, 32'h0, 1'b0, 32'h0000_9ABC, 1'b0, 2, 1), 1'b0);
        access("sh", 1'b1, MASK_H, 1'b0, 32'h40A, 32'h0000_BEEF, 32'h0, 0,
               mk(32'h408, 4'b1100, 32'hBEEF_0000, 1'b1, 32'h0, 1'b0, 2, 1), 1'b0);
        access("lw_sz3", 1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 32'h89AB_CDEF, 0,
               mk(32'h010, 4'b1111, 32'h0, 1'b0, 32'h89AB_CDEF, 1'b0, 2, 1), 1'b0);

        // 4: misaligned SW
`ifdef RISCV_MISALIGN_TRAP_EN
        access("sw_mis", 1'b1, MASK_X, 1'b0, 32'h302, 32'h1122_3344, 32'h0, 0,
               mk(32'h0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0), 1'b0);
`else
        access("sw_mis", 1'b1, MASK_X, 1'b0, 32'h302, 32'h1122_3344, 32'h0, 0,
               mk(32'h300, 4'b1111, 32'h1122_3344, 1'b1, 32'h0, 1'b0, 2, 1), 1'b0);
`endif

        // 5: reset during BUS aborts the access without lsu_done
        @(negedge clk);
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_size = MASK_X; lsu_addr = 32'h500;
        dmem_ack = 1'b0;
        @(negedge clk); #1;
        chk("abort_req_bus", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1; lsu_valid = 1'b0;
        @(negedge clk); #1;
        chk("abort_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("abort_no_done", {31'd0, lsu_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("abort_no_done2", {31'd0, lsu_done}, 32'd0);
        access("sw_after", 1'b1, MASK_X, 1'b0, 32'h600, 32'hA5A5_0F0F, 32'h0, 2,
               mk(32'h600, 4'b1111, 32'hA5A5_0F0F, 1'b1, 32'h0, 1'b0, 4, 3), 1'b0);

        // 6: back-to-back SB then LW with lsu_valid held high
        access("b2b_sb", 1'b1, MASK_B, 1'b0, 32'h002, 32'h0000_005A, 32'h0, 0,
               mk(32'h000, 4'b0100, 32'h005A_0000, 1'b1, 32'h0, 1'b0, 2, 1), 1'b1);
        access("b2b_lw", 1'b0, MASK_X, 1'b0, 32'h040, 32'h0, 32'hCAFE_BABE, 0,
               mk(32'h040, 4'b1111, 32'h0, 1'b0, 32'hCAFE_BABE, 1'b0, 2, 1), 1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
